inst_fetch_mem: RTL
===================

Name: inst_fetch_mem

Overview:
Parametrised, byte-addressed instruction memory with a pipelined fetch port and a valid/ready handshake. It also has a byte-wide program-load port and range/alignment exception reporting with a saturating exception counter. It sits between the PC/fetch stage and the decode stage, and is the successor to the single-cycle 16-bit instruction memory. It adds configurable fetch width, read latency, backpressure and program loading.

Parameters:
ADDR_WIDTH, 16, byte-address width of req_addr and load_addr
DATA_WIDTH, 16, fetch width in bits; must be a multiple of 8; BYTES = DATA_WIDTH/8
MEM_SIZE, 4096, memory size in bytes
READ_LATENCY, 1, cycles from request acceptance to response; legal range 1..4
ALIGN_CHECK, 1, 1 = flag fetches not aligned to BYTES; 0 = misaligned fetch allowed
EXC_CNT_WIDTH, 8, width of the saturating exception counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  1  fetch request valid
req_ready  output  1  fetch request accepted when req_valid && req_ready at clk rise
req_addr  input  ADDR_WIDTH  byte address of fetch
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_WIDTH  fetched instruction, little-endian
rsp_exc  output  2  exception code: 00 none, 01 range, 10 align
load_en  input  1  program-load byte write strobe
load_addr  input  ADDR_WIDTH  load byte address
load_data  input  8  load byte value
exc_cnt  output  EXC_CNT_WIDTH  count of responses with nonzero rsp_exc, saturating

Behaviour:
- Reset (rst low, async): rsp_valid=0, rsp_data=0, rsp_exc=00, exc_cnt=0, all pipeline valid bits cleared. Memory contents are retained, not cleared. Reset mid-operation drops all in-flight fetches with no response.
- Memory: MEM_SIZE bytes. rsp_data = {mem[a+BYTES-1], ..., mem[a]}, so the lowest address is the LSB.
- req_ready = !load_en && !(rsp_valid && !rsp_ready). Combinational; no dependence on req_valid.
- Load: when load_en=1 and load_addr<MEM_SIZE, mem[load_addr] is written at clk rise. When load_addr>=MEM_SIZE the write is dropped silently. Loading does not stall in-flight fetches.
- Fetch pipeline: READ_LATENCY stages of {valid, data, exc}. Stage 0 samples memory at acceptance. A request accepted at edge N gives rsp_valid=1 after edge N+READ_LATENCY-1, i.e. during cycle N+READ_LATENCY, unless stalled.
- Throughput: one fetch per cycle with rsp_ready held at 1.
- Stall: while rsp_valid && !rsp_ready, all stages hold and no new request is accepted. rsp_data and rsp_exc stay stable until accepted.
- Read/load ordering: a fetch samples memory at acceptance. A load to the same byte after acceptance does not affect that response.
- Exceptions are evaluated at acceptance:
  - Range, code 01: a + BYTES - 1 >= MEM_SIZE. Compute at ADDR_WIDTH+1 bits so the address cannot wrap.
  - Align, code 10: ALIGN_CHECK=1 and a % BYTES != 0.
  - Range has priority over align.
  - On any exception rsp_data = 0 and memory is not read.
- exc_cnt increments by 1 on each response handshake (rsp_valid && rsp_ready) with rsp_exc != 00. It saturates at all-ones.
- No state machine beyond the pipeline valid bits and the stall condition. Pipeline states per slot: EMPTY, FULL; FULL->EMPTY on advance without refill.

Decomposition:
- Package inst_mem_pkg holds the exception codes EXC_NONE=2'b00, EXC_RANGE=2'b01 and EXC_ALIGN=2'b10, plus a function computing BYTES from DATA_WIDTH.
- One sub-module, inst_mem_pipe_stage: a single {valid, data, exc} register slot with hold enable, instantiated READ_LATENCY times via generate.
- Byte array, exception check and counter stay in the top module.

Test Plan:
- Load and fetch, defaults: load bytes 0x34@0, 0x12@1, 0x78@2, 0x56@3; fetch 0 then 2 back-to-back -> rsp_data 0x1234 then 0x5678 on consecutive cycles, one cycle after acceptance, rsp_exc=00.
- Range boundary: fetch 4094 -> valid data, exc 00. Fetch 4095 -> exc 01, data 0. Fetch 0xFFFF -> exc 01, no wrap.
- Alignment: fetch 3 -> exc 10, exc_cnt=1. Rebuild with ALIGN_CHECK=0 and fetch 3 -> {mem[4],mem[3]}, exc 00.
- Backpressure, READ_LATENCY=3: issue 4 fetches, hold rsp_ready=0 for 5 cycles -> req_ready=0, rsp_data stable; release -> 4 responses in order, none lost or duplicated.
- Load priority and ordering: load_en=1 with req_valid=1 -> req_ready=0. Fetch addr 8 accepted, then load 0xAA@8 next cycle -> response shows the old byte.
- Reset mid-flight and counter saturation: assert rst with 2 fetches in flight -> rsp_valid=0, no responses; memory retained on refetch. With EXC_CNT_WIDTH=2, issue 5 exceptions -> exc_cnt=3.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared types for the instruction fetch memory: exception codes and fetch-width helper.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package inst_mem_pkg;

   typedef enum logic [1:0] {
      EXC_NONE  = 2'b00,
      EXC_RANGE = 2'b01,
      EXC_ALIGN = 2'b10
   } exc_code_t;

   // Number of bytes returned per fetch for a given fetch width in bits.
   function automatic int calc_bytes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/inst_fetch_mem_if.sv
// Fetch/response/load bundle between the fetch stage, the instruction memory and decode.
// Latency: none (wires only).
// Backpressure: carries req_valid/req_ready and rsp_valid/rsp_ready handshakes.
// Ports: master = fetch/load driver side, slave = memory side.
interface inst_fetch_mem_if
   import inst_mem_pkg::*;
#(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int EXC_CNT_WIDTH = 8
);
   logic                     req_valid;
   logic                     req_ready;
   logic [ADDR_WIDTH-1:0]    req_addr;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [DATA_WIDTH-1:0]    rsp_data;
   exc_code_t                rsp_exc;
   logic                     load_en;
   logic [ADDR_WIDTH-1:0]    load_addr;
   logic [7:0]               load_data;
   logic [EXC_CNT_WIDTH-1:0] exc_cnt;

   modport master (
      output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
      input  req_ready, rsp_valid, rsp_data, rsp_exc, exc_cnt
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
      output req_ready, rsp_valid, rsp_data, rsp_exc, exc_cnt
   );
endinterface

// File: rtl/inst_mem_pipe_stage.sv
// One {valid, data, exc} slot of the fetch read pipeline.
// Latency: 1 cycle when enabled.
// Backpressure: en=0 holds the slot contents unchanged.
// Ports: clk/rst, en, in_* (slot input), out_* (registered slot contents).
module inst_mem_pipe_stage
   import inst_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  exc_code_t             in_exc,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output exc_code_t             out_exc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_exc   <= EXC_NONE;
      end else if (en) begin
         out_valid <= in_valid;
         out_data  <= in_data;
         out_exc   <= in_exc;
      end
   end

endmodule

// File: rtl/inst_fetch_mem.sv
// Byte-addressed instruction memory with pipelined fetch, byte program-load port and exception counter.
// Latency: READ_LATENCY cycles from request acceptance to rsp_valid, one fetch per cycle.
// Backpressure: rsp_valid && !rsp_ready freezes every stage and drops req_ready; load_en also drops req_ready.
// Ports: clk, rst (async active-low), bus (slave side of inst_fetch_mem_if).
module inst_fetch_mem
   import inst_mem_pkg::*;
#(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int MEM_SIZE      = 4096,
   parameter int READ_LATENCY  = 1,
   parameter int ALIGN_CHECK   = 1,
   parameter int EXC_CNT_WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   inst_fetch_mem_if.slave bus
);

   localparam int BYTES = calc_bytes(DATA_WIDTH);
   localparam int MIW   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

   logic [7:0] mem [MEM_SIZE];

   logic                  stall;
   logic                  accept;
   logic [ADDR_WIDTH:0]   last_addr;
   logic                  range_err;
   logic                  align_err;
   exc_code_t             fetch_exc;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH:0]   rd_idx;

   logic [READ_LATENCY:0] pv;
   logic [DATA_WIDTH-1:0] pd [READ_LATENCY+1];
   exc_code_t             pe [READ_LATENCY+1];

   assign stall         = bus.rsp_valid && !bus.rsp_ready;
   assign bus.req_ready = !bus.load_en && !stall;
   assign accept        = bus.req_valid && bus.req_ready;

   // Program load; out-of-range bytes are dropped instead of aliasing into the array.
   always_ff @(posedge clk) begin
      if (bus.load_en && ({1'b0, bus.load_addr} < MEM_LIMIT)) begin
         mem[bus.load_addr[MIW-1:0]] <= bus.load_data;
      end
   end

   // Last byte computed one bit wider so a fetch near the top of the address space cannot wrap to 0.
   assign last_addr = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(BYTES - 1);
   assign range_err = (last_addr >= MEM_LIMIT);
   assign align_err = (ALIGN_CHECK != 0) && ((32'(bus.req_addr) % 32'(BYTES)) != 32'd0);

   always_comb begin
      fetch_exc = EXC_NONE;
      if (range_err) begin
         fetch_exc = EXC_RANGE;
      end else if (align_err) begin
         fetch_exc = EXC_ALIGN;
      end
   end

   // Little-endian assembly: lowest address lands in the least significant byte.
   always_comb begin
      rd_data = '0;
      rd_idx  = '0;
      if (fetch_exc == EXC_NONE) begin
         for (int b = 0; b < BYTES; b++) begin
            rd_idx = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(b);
            rd_data[b*8 +: 8] = mem[rd_idx[MIW-1:0]];
         end
      end
   end

   // Slot 0 input is the memory sample taken at acceptance; bubbles carry zero data.
   assign pv[0] = accept;
   assign pd[0] = accept ? rd_data : '0;
   assign pe[0] = accept ? fetch_exc : EXC_NONE;

   for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
      inst_mem_pipe_stage #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en        (!stall),
         .in_valid  (pv[i]),
         .in_data   (pd[i]),
         .in_exc    (pe[i]),
         .out_valid (pv[i+1]),
         .out_data  (pd[i+1]),
         .out_exc   (pe[i+1])
      );
   end

   assign bus.rsp_valid = pv[READ_LATENCY];
   assign bus.rsp_data  = pd[READ_LATENCY];
   assign bus.rsp_exc   = pe[READ_LATENCY];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.exc_cnt <= '0;
      end else if (bus.rsp_valid && bus.rsp_ready && (bus.rsp_exc != EXC_NONE)
                   && (bus.exc_cnt != {EXC_CNT_WIDTH{1'b1}})) begin
         bus.exc_cnt <= bus.exc_cnt + 1'b1;
      end
   end

endmodule
